// File: rtl/soc_system_pio_out_pkg.sv
// soc_system_pio_out_pkg: shared bus widths, register addresses and pulse engine states.
package soc_system_pio_out_pkg;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] ADDR_DATA      = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_PULSE_LEN = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_PULSE     = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_STATUS    = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET    = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR  = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_EN    = 3'd6;

    localparam int STATUS_DONE = 0;
    localparam int STATUS_BUSY = 1;

    typedef enum logic {PS_IDLE, PS_ACTIVE} pulse_state_e;
endpackage

// File: rtl/soc_system_pio_out_if.sv
// soc_system_pio_out_if: Avalon-MM slave bus for the output PIO.
//   address, chipselect, write_n, writedata : master -> slave
//   readdata                                : slave -> master, 1-cycle latency
interface soc_system_pio_out_if;
    import soc_system_pio_out_pkg::*;
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/soc_system_pio_pulse_timer.sv
// soc_system_pio_pulse_timer: retriggerable one-shot mask with sticky done flag.
//   trigger/trig_bits : start or retrigger; zero trig_bits is ignored
//   len               : pulse length in clk cycles, 0 treated as 1
//   done_clr          : clear done (a same-cycle set wins)
//   mask, busy, done  : active bits, mask != 0, sticky expiry flag
module soc_system_pio_pulse_timer
    import soc_system_pio_out_pkg::*;
#(
    parameter int WIDTH   = 12,
    parameter int PULSE_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               trigger,
    input  logic [WIDTH-1:0]   trig_bits,
    input  logic [PULSE_W-1:0] len,
    input  logic               done_clr,
    output logic [WIDTH-1:0]   mask,
    output logic               busy,
    output logic               done
);
    pulse_state_e       state, state_d;
    logic [PULSE_W-1:0] cnt, cnt_d;
    logic [WIDTH-1:0]   mask_d;
    logic               done_set;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= PS_IDLE;
            mask  <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            mask  <= mask_d;
            cnt   <= cnt_d;
            done  <= done_set | (done & ~done_clr);
        end
    end

    // A trigger outranks expiry in the same cycle, so a retrigger on the
    // last active cycle extends the pulse without raising done.
    always_comb begin
        state_d  = state;
        mask_d   = mask;
        cnt_d    = cnt;
        done_set = 1'b0;
        if (trigger && trig_bits != '0) begin
            state_d = PS_ACTIVE;
            mask_d  = mask | trig_bits;
            cnt_d   = (len == '0) ? PULSE_W'(1) : len;
        end else if (state == PS_ACTIVE) begin
            if (cnt > PULSE_W'(1)) begin
                cnt_d = cnt - PULSE_W'(1);
            end else begin
                state_d  = PS_IDLE;
                mask_d   = '0;
                cnt_d    = '0;
                done_set = 1'b1;
            end
        end
    end

    assign busy = (state == PS_ACTIVE);
endmodule

// File: rtl/soc_system_pio_out.sv
// soc_system_pio_out: Avalon-MM output PIO with set/clear aliases and one-shot pulses.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   out_port     : data register ORed with the active pulse mask
//   irq          : registered done & irq_en
module soc_system_pio_out
    import soc_system_pio_out_pkg::*;
#(
    parameter int               WIDTH       = 12,
    parameter int               PULSE_W     = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    soc_system_pio_out_if.slave  bus,
    output logic [WIDTH-1:0]     out_port,
    output logic                 irq
);
    logic [WIDTH-1:0]   data_reg;
    logic [PULSE_W-1:0] len_reg;
    logic               irq_en;
    logic [WIDTH-1:0]   mask;
    logic               busy;
    logic               done;
    logic               wr;
    logic [WIDTH-1:0]   wbits;
    logic [DATA_W-1:0]  rd_mux;

    assign wr    = bus.chipselect & ~bus.write_n;
    assign wbits = bus.writedata[WIDTH-1:0];

    soc_system_pio_pulse_timer #(.WIDTH(WIDTH), .PULSE_W(PULSE_W)) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .trigger   (wr && bus.address == ADDR_PULSE),
        .trig_bits (wbits),
        .len       (len_reg),
        .done_clr  (wr && bus.address == ADDR_STATUS && bus.writedata[STATUS_DONE]),
        .mask      (mask),
        .busy      (busy),
        .done      (done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg     <= RESET_VALUE;
            len_reg      <= '0;
            irq_en       <= 1'b0;
            bus.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            if (wr && bus.address == ADDR_DATA)
                data_reg <= wbits;
            else if (wr && bus.address == ADDR_OUTSET)
                data_reg <= data_reg | wbits;
            else if (wr && bus.address == ADDR_OUTCLEAR)
                data_reg <= data_reg & ~wbits;
            if (wr && bus.address == ADDR_PULSE_LEN)
                len_reg <= bus.writedata[PULSE_W-1:0];
            if (wr && bus.address == ADDR_IRQ_EN)
                irq_en <= bus.writedata[0];
            bus.readdata <= rd_mux;
            irq          <= done & irq_en;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:      rd_mux = DATA_W'(data_reg);
            ADDR_PULSE_LEN: rd_mux = DATA_W'(len_reg);
            ADDR_PULSE:     rd_mux = DATA_W'(mask);
            ADDR_STATUS: begin
                rd_mux[STATUS_DONE] = done;
                rd_mux[STATUS_BUSY] = busy;
            end
            ADDR_IRQ_EN:    rd_mux[0] = irq_en;
            default:        rd_mux = '0;
        endcase
    end

    assign out_port = data_reg | mask;
endmodule

// File: tb/tb_soc_system_pio_out.sv
// tb_soc_system_pio_out: directed self-checking bench for soc_system_pio_out.
module tb_soc_system_pio_out;
    import soc_system_pio_out_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] out_port;
    logic        irq;
    logic [31:0] d;
    int          n_tests = 0;
    int          n_fail  = 0;

    soc_system_pio_out_if bus();

    soc_system_pio_out #(.WIDTH(12), .PULSE_W(16), .RESET_VALUE(12'h000)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .out_port (out_port),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; the write is sampled by the next rising edge
    // and the task returns on the following falling edge.
    task automatic bus_wr(input logic [2:0] a, input logic [31:0] v);
        bus.address    = a;
        bus.writedata  = v;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] v);
        bus.address = a;
        @(negedge clk);
        v = bus.readdata;
    endtask

    initial begin
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        reset_n        = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // reset state
        check("rst_out", 32'(out_port), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        for (int a = 0; a < 8; a++) begin
            bus_rd(3'(a), d);
            check($sformatf("rst_rd%0d", a), d, 32'h0);
        end

        // data register with set/clear aliases
        bus_wr(ADDR_DATA, 32'h0F0);
        check("data_wr", 32'(out_port), 32'h0F0);
        bus_wr(ADDR_OUTSET, 32'h003);
        check("outset", 32'(out_port), 32'h0F3);
        bus_wr(ADDR_OUTCLEAR, 32'h010);
        check("outclear", 32'(out_port), 32'h0E3);
        bus_rd(ADDR_DATA, d);
        check("data_rd", d, 32'h0E3);
        bus_rd(ADDR_OUTSET, d);
        check("outset_rd", d, 32'h0);
        bus_rd(ADDR_OUTCLEAR, d);
        check("outclear_rd", d, 32'h0);
        bus_wr(ADDR_DATA, 32'h0);

        // 5-cycle pulse, status, irq and W1C
        bus_wr(ADDR_IRQ_EN, 32'h1);
        bus_wr(ADDR_PULSE_LEN, 32'd5);
        bus_rd(ADDR_PULSE_LEN, d);
        check("len_rd", d, 32'd5);
        bus_wr(ADDR_PULSE, 32'h100);
        bus.address = ADDR_STATUS;
        check("p5_c0", 32'(out_port), 32'h100);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("p5_c%0d", i), 32'(out_port), 32'h100);
            if (i == 1) check("p5_busy", bus.readdata, 32'h2);
        end
        @(negedge clk);
        check("p5_end", 32'(out_port), 32'h0);
        check("p5_irq_lag", 32'(irq), 32'h0);
        @(negedge clk);
        check("p5_irq", 32'(irq), 32'h1);
        check("p5_done", bus.readdata, 32'h1);
        bus_wr(ADDR_STATUS, 32'h1);
        @(negedge clk);
        check("w1c_irq", 32'(irq), 32'h0);
        check("w1c_status", bus.readdata, 32'h0);

        // retrigger: bits 0 and 1 fall together 10 cycles after the second write
        bus_wr(ADDR_PULSE_LEN, 32'd10);
        bus_wr(ADDR_PULSE, 32'h001);
        check("rt_first", 32'(out_port), 32'h001);
        repeat (3) @(negedge clk);
        bus_wr(ADDR_PULSE, 32'h002);
        bus.address = ADDR_PULSE;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("rt_c%0d", i), 32'(out_port), 32'h003);
            check($sformatf("rt_irq%0d", i), 32'(irq), 32'h0);
            if (i == 1) check("rt_mask_rd", bus.readdata, 32'h003);
            @(negedge clk);
        end
        check("rt_end", 32'(out_port), 32'h0);
        @(negedge clk);
        check("rt_irq", 32'(irq), 32'h1);
        bus_wr(ADDR_STATUS, 32'h1);
        repeat (10) @(negedge clk);
        check("rt_done_once", 32'(irq), 32'h0);

        // zero length means one cycle
        bus_wr(ADDR_PULSE_LEN, 32'd0);
        bus_wr(ADDR_PULSE, 32'h800);
        check("len0_c0", 32'(out_port), 32'h800);
        @(negedge clk);
        check("len0_end", 32'(out_port), 32'h0);
        @(negedge clk);
        check("len0_irq", 32'(irq), 32'h1);

        // zero-valued PULSE write is ignored
        bus_wr(ADDR_PULSE, 32'h0);
        check("pulse0", 32'(out_port), 32'h0);

        // asynchronous reset in the middle of a long pulse
        bus_wr(ADDR_DATA, 32'h005);
        bus_wr(ADDR_PULSE_LEN, 32'd100);
        bus_wr(ADDR_PULSE, 32'h800);
        repeat (3) @(negedge clk);
        check("ar_pre_out", 32'(out_port), 32'h805);
        check("ar_pre_irq", 32'(irq), 32'h1);
        check("ar_pre_rd", bus.readdata, 32'h800);
        #2 reset_n = 1'b0;
        #1;
        check("ar_out", 32'(out_port), 32'h0);
        check("ar_irq", 32'(irq), 32'h0);
        check("ar_rd", bus.readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_rd(ADDR_PULSE, d);
        check("ar_mask", d, 32'h0);
        bus_rd(ADDR_STATUS, d);
        check("ar_status", d, 32'h0);
        bus_rd(ADDR_IRQ_EN, d);
        check("ar_irq_en", d, 32'h0);
        bus_rd(ADDR_PULSE_LEN, d);
        check("ar_len", d, 32'h0);
        check("ar_post_out", 32'(out_port), 32'h0);

        // retrigger on the exact expiry cycle
        bus_wr(ADDR_IRQ_EN, 32'h1);
        bus_wr(ADDR_PULSE_LEN, 32'd3);
        bus_wr(ADDR_PULSE, 32'h004);
        check("ex_c0", 32'(out_port), 32'h004);
        @(negedge clk);
        check("ex_c1", 32'(out_port), 32'h004);
        @(negedge clk);
        check("ex_c2", 32'(out_port), 32'h004);
        bus_wr(ADDR_PULSE, 32'h004);
        for (int i = 3; i < 6; i++) begin
            check($sformatf("ex_c%0d", i), 32'(out_port), 32'h004);
            check($sformatf("ex_irq%0d", i), 32'(irq), 32'h0);
            @(negedge clk);
        end
        check("ex_end", 32'(out_port), 32'h0);
        check("ex_irq_lag", 32'(irq), 32'h0);
        @(negedge clk);
        check("ex_irq", 32'(irq), 32'h1);

        // done set and W1C in the same cycle: set wins
        bus_wr(ADDR_STATUS, 32'h1);
        @(negedge clk);
        check("sc_clr_irq", 32'(irq), 32'h0);
        bus_wr(ADDR_PULSE_LEN, 32'd2);
        bus_wr(ADDR_PULSE, 32'h010);
        @(negedge clk);
        bus_wr(ADDR_STATUS, 32'h1);
        check("sc_end", 32'(out_port), 32'h0);
        @(negedge clk);
        check("sc_done", bus.readdata, 32'h1);
        check("sc_irq", 32'(irq), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
